// File: rtl/const_div_pkg.sv
// Shared types and elaboration-time helpers for the constant-divisor sequential divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package const_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Remainder is always < divisor, so clog2(divisor) bits suffice.
    function automatic int calc_rem_w(input int divisor);
        return $clog2(divisor);
    endfunction

    // Number of radix-2^chunk digit steps needed to cover width bits.
    function automatic int calc_n_steps(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/const_div_step.sv
// One radix-2^CHUNK_W long-division digit step against a constant divisor.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; no handshake.
// Ports: rem_in (partial remainder, < DIVISOR), chunk (next dividend digit),
//        q_digit (quotient digit), rem_out (new partial remainder).
module const_div_step
    import const_div_pkg::*;
#(
    parameter int DIVISOR = 113,
    parameter int CHUNK_W = 2,
    parameter int REM_W   = calc_rem_w(DIVISOR)
) (
    input  logic [REM_W-1:0]   rem_in,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [CHUNK_W-1:0] q_digit,
    output logic [REM_W-1:0]   rem_out
);

    localparam int              V_W   = REM_W + CHUNK_W;
    localparam logic [V_W-1:0]  DIV_V = V_W'(DIVISOR);

    logic [V_W-1:0] v;

    assign v = {rem_in, chunk};

    // Divisor is a constant, so synthesis folds this into a fixed
    // V_W-input lookup table. Since rem_in < DIVISOR the quotient
    // always fits in CHUNK_W bits; the cast drops only zero bits.
    assign q_digit = CHUNK_W'(v / DIV_V);
    assign rem_out = REM_W'(v % DIV_V);

endmodule

// File: rtl/const_div_seq.sv
// Digit-serial unsigned divide by constant DIVISOR, CHUNK_W dividend bits per cycle, MSB first.
// Latency: ceil(DIVIDEND_W/CHUNK_W) cycles accept->out_valid; with CONST_DIV_EARLY_EXIT_EN
//          defined, max(1, steps left after skipping leading all-zero chunks).
// Backpressure: result held in DONE until out_ready; in_ready low until the cycle after that handshake.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_dividend operand handshake;
//        out_valid/out_ready/out_quot/out_rem result handshake; busy high while dividing.
module const_div_seq
    import const_div_pkg::*;
#(
    parameter int DIVIDEND_W = 24,
    parameter int DIVISOR    = 113,
    parameter int CHUNK_W    = 2,
    parameter int REM_W      = calc_rem_w(DIVISOR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_dividend,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] out_quot,
    output logic [REM_W-1:0]      out_rem,
    output logic                  busy
);

    localparam int               N_STEPS  = calc_n_steps(DIVIDEND_W, CHUNK_W);
    localparam int               PAD_W    = N_STEPS * CHUNK_W;
    localparam int               CNT_W    = $clog2(N_STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_STEPS - 1);

    div_state_t              state_q, state_d;
    logic [PAD_W-1:0]        sr_q, sr_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic [DIVIDEND_W-1:0]   quot_q, quot_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic [PAD_W-1:0]        padded;
    logic [PAD_W-1:0]        start_sr;
    logic [CNT_W-1:0]        start_cnt;
    logic [CHUNK_W-1:0]      step_q;
    logic [REM_W-1:0]        step_rem;

    assign accept = in_valid & in_ready;
    assign padded = PAD_W'(in_dividend);

`ifdef CONST_DIV_EARLY_EXIT_EN
    // Leading all-zero chunks would only produce d=0, rem=0, so skip them.
    // At least one step always runs so a zero dividend still passes RUN.
    logic [CNT_W-1:0] lz;
    logic             found;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = N_STEPS - 1; i >= 0; i--) begin
            if (!found) begin
                if (padded[i*CHUNK_W +: CHUNK_W] == '0) begin
                    lz = lz + CNT_W'(1);
                end else begin
                    found = 1'b1;
                end
            end
        end
    end

    assign start_cnt = (lz == CNT_W'(N_STEPS)) ? LAST_CNT : lz;
    assign start_sr  = padded << (CHUNK_W * start_cnt);
`else
    assign start_cnt = '0;
    assign start_sr  = padded;
`endif

    const_div_step #(
        .DIVISOR (DIVISOR),
        .CHUNK_W (CHUNK_W),
        .REM_W   (REM_W)
    ) u_step (
        .rem_in  (rem_q),
        .chunk   (sr_q[PAD_W-1 -: CHUNK_W]),
        .q_digit (step_q),
        .rem_out (step_rem)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)              state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
    end

    // Datapath next state
    always_comb begin
        sr_d   = sr_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        cnt_d  = cnt_q;
        if (accept) begin
            sr_d   = start_sr;
            rem_d  = '0;
            quot_d = '0;
            cnt_d  = start_cnt;
        end else if (state_q == RUN) begin
            sr_d   = sr_q << CHUNK_W;
            rem_d  = step_rem;
            quot_d = DIVIDEND_W'({quot_q, step_q});
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            cnt_q  <= cnt_d;
        end
    end

    // Result registers double as the output bus; they only change in RUN
    // or on accept, so they stay stable throughout DONE.
    assign out_quot = quot_q;
    assign out_rem  = rem_q;

endmodule

// File: tb/tb_const_div_seq.sv
// Self-checking bench for const_div_seq: directed cases on a default instance plus
// randomized dividends across a grid of divisor/radix instances.
// Expected results come from plain integer division and a bit-length latency model.
module tb_const_div_seq;

    localparam int NCFG = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance
    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
    logic [23:0] m_dividend, m_quot;
    logic [6:0]  m_rem;

    const_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (m_in_valid),
        .in_ready    (m_in_ready),
        .in_dividend (m_dividend),
        .out_valid   (m_out_valid),
        .out_ready   (m_out_ready),
        .out_quot    (m_quot),
        .out_rem     (m_rem),
        .busy        (m_busy)
    );

    // Grid of instances: DIVISOR {3,7,113,255} x CHUNK_W {1,2,4}
    logic        a_in_valid, a_out_ready;
    logic [23:0] a_dividend;
    logic        a_in_ready  [NCFG];
    logic        a_out_valid [NCFG];
    logic        a_busy      [NCFG];
    logic [23:0] a_quot      [NCFG];
    logic [7:0]  a_rem       [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int D  = (g / 3 == 0) ? 3 : (g / 3 == 1) ? 7 : (g / 3 == 2) ? 113 : 255;
        localparam int C  = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 2 : 4;
        localparam int RW = $clog2(D);
        logic [RW-1:0] r_loc;
        const_div_seq #(
            .DIVIDEND_W (24),
            .DIVISOR    (D),
            .CHUNK_W    (C)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (a_in_valid),
            .in_ready    (a_in_ready[g]),
            .in_dividend (a_dividend),
            .out_valid   (a_out_valid[g]),
            .out_ready   (a_out_ready),
            .out_quot    (a_quot[g]),
            .out_rem     (r_loc),
            .busy        (a_busy[g])
        );
        assign a_rem[g] = 8'(r_loc);
    end

    int errors = 0;
    int checks = 0;

    function automatic int div_of(input int i);
        case (i / 3)
            0:       return 3;
            1:       return 7;
            2:       return 113;
            default: return 255;
        endcase
    endfunction

    function automatic int chunk_of(input int i);
        case (i % 3)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    // Cycles from accepting edge to out_valid.
    function automatic int exp_lat(input logic [23:0] d, input int ch);
        int n;
        n = (24 + ch - 1) / ch;
`ifdef CONST_DIV_EARLY_EXIT_EN
        begin
            int bits;
            bits = 0;
            for (int b = 0; b < 24; b++) if (d[b]) bits = b + 1;
            n = (bits + ch - 1) / ch;
            if (n < 1) n = 1;
        end
`else
        if (d === 24'hx) n = -1;
`endif
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_main(input logic [23:0] d);
        m_dividend = d;
        m_in_valid = 1'b1;
        tick();
        m_in_valid = 1'b0;
        m_dividend = 24'($urandom);
    endtask

    task automatic wait_main(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (m_out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic hs_main();
        m_out_ready = 1'b1;
        tick();
        m_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (m_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", m_in_ready); end
        if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", m_out_valid); end
        if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", m_busy); end
        if (m_quot !== 24'd0) begin errors++; $display("FAIL reset_quot got=%0d want=0", m_quot); end
        if (m_rem !== 7'd0) begin errors++; $display("FAIL reset_rem got=%0d want=0", m_rem); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [23:0] dv [6] = '{24'hFFFFFF, 24'd113, 24'd112, 24'd0, 24'd1000, 24'd226};
        int          qv [6] = '{148470, 1, 0, 0, 8, 2};
        int          rv [6] = '{105, 0, 112, 0, 96, 0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            start_main(dv[i]);
            checks += 2;
            if (m_busy !== 1'b1) begin errors++; $display("FAIL dir_busy d=%0d got=%b want=1", dv[i], m_busy); end
            if (m_in_ready !== 1'b0) begin errors++; $display("FAIL dir_in_ready_run d=%0d got=%b want=0", dv[i], m_in_ready); end
            wait_main(lat);
            checks += 3;
            if (lat != exp_lat(dv[i], 2)) begin errors++; $display("FAIL dir_latency d=%0d got=%0d want=%0d", dv[i], lat, exp_lat(dv[i], 2)); end
            if (m_quot !== 24'(qv[i])) begin errors++; $display("FAIL dir_quot d=%0d got=%0d want=%0d", dv[i], m_quot, qv[i]); end
            if (m_rem !== 7'(rv[i])) begin errors++; $display("FAIL dir_rem d=%0d got=%0d want=%0d", dv[i], m_rem, rv[i]); end
            hs_main();
            checks += 2;
            if (m_in_ready !== 1'b1) begin errors++; $display("FAIL dir_idle_in_ready d=%0d got=%b want=1", dv[i], m_in_ready); end
            if (m_out_valid !== 1'b0) begin errors++; $display("FAIL dir_idle_out_valid d=%0d got=%b want=0", dv[i], m_out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] d;
        int lat;
        d = 24'($urandom);
        start_main(d);
        wait_main(lat);
        checks++;
        if (lat != exp_lat(d, 2)) begin errors++; $display("FAIL bp_latency got=%0d want=%0d", lat, exp_lat(d, 2)); end
        // Offer another operand while stalled; it must be ignored.
        m_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_dividend = 24'($urandom);
            checks += 4;
            if (m_out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", k, m_out_valid); end
            if (m_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, m_in_ready); end
            if (m_quot !== 24'(d / 113)) begin errors++; $display("FAIL bp_quot cyc=%0d got=%0d want=%0d", k, m_quot, d / 113); end
            if (m_rem !== 7'(d % 113)) begin errors++; $display("FAIL bp_rem cyc=%0d got=%0d want=%0d", k, m_rem, d % 113); end
            tick();
        end
        m_in_valid = 1'b0;
        hs_main();
        checks += 4;
        if (m_in_ready !== 1'b1) begin errors++; $display("FAIL bp_post_in_ready got=%b want=1", m_in_ready); end
        if (m_out_valid !== 1'b0) begin errors++; $display("FAIL bp_post_out_valid got=%b want=0", m_out_valid); end
        if (m_busy !== 1'b0) begin errors++; $display("FAIL bp_post_busy got=%b want=0", m_busy); end
        if (m_quot !== 24'(d / 113)) begin errors++; $display("FAIL bp_post_hold got=%0d want=%0d", m_quot, d / 113); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit spurious;
        start_main(24'h123456);
        repeat (6) tick();
        checks++;
        if (m_busy !== 1'b1) begin errors++; $display("FAIL rmr_busy_before got=%b want=1", m_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 3;
        if (m_out_valid !== 1'b0) begin errors++; $display("FAIL rmr_out_valid got=%b want=0", m_out_valid); end
        if (m_in_ready !== 1'b1) begin errors++; $display("FAIL rmr_in_ready got=%b want=1", m_in_ready); end
        if (m_busy !== 1'b0) begin errors++; $display("FAIL rmr_busy got=%b want=0", m_busy); end
        spurious = 1'b0;
        repeat (15) begin
            tick();
            if (m_out_valid !== 1'b0) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL rmr_no_result got=1 want=0"); end
        start_main(24'd1000);
        wait_main(lat);
        checks += 3;
        if (lat != exp_lat(24'd1000, 2)) begin errors++; $display("FAIL rmr_latency got=%0d want=%0d", lat, exp_lat(24'd1000, 2)); end
        if (m_quot !== 24'd8) begin errors++; $display("FAIL rmr_quot got=%0d want=8", m_quot); end
        if (m_rem !== 7'd96) begin errors++; $display("FAIL rmr_rem got=%0d want=96", m_rem); end
        hs_main();
    endtask

    task automatic test_random_configs();
        logic [23:0] d;
        int unsigned du;
        int lat [NCFG];
        bit all;
        for (int it = 0; it < 800; it++) begin
            d  = 24'($urandom) & (24'hFFFFFF >> $urandom_range(0, 23));
            if (it == 0) d = 24'hFFFFFF;
            if (it == 1) d = 24'd0;
            du = 32'(d);
            a_dividend = d;
            a_in_valid = 1'b1;
            tick();
            a_in_valid = 1'b0;
            for (int i = 0; i < NCFG; i++) begin
                lat[i] = -1;
                checks++;
                if (a_busy[i] !== 1'b1) begin errors++; $display("FAIL rnd_busy cfg=%0d d=%0d got=%b want=1", i, d, a_busy[i]); end
            end
            for (int k = 1; k <= 40; k++) begin
                tick();
                all = 1'b1;
                for (int i = 0; i < NCFG; i++) begin
                    if (a_out_valid[i] && lat[i] < 0) lat[i] = k;
                    if (lat[i] < 0) all = 1'b0;
                end
                if (all) break;
            end
            for (int i = 0; i < NCFG; i++) begin
                checks += 3;
                if (lat[i] != exp_lat(d, chunk_of(i))) begin
                    errors++;
                    $display("FAIL rnd_latency cfg=%0d d=%0d got=%0d want=%0d", i, d, lat[i], exp_lat(d, chunk_of(i)));
                end
                if (a_quot[i] !== 24'(du / div_of(i))) begin
                    errors++;
                    $display("FAIL rnd_quot cfg=%0d d=%0d got=%0d want=%0d", i, d, a_quot[i], du / div_of(i));
                end
                if (a_rem[i] !== 8'(du % div_of(i))) begin
                    errors++;
                    $display("FAIL rnd_rem cfg=%0d d=%0d got=%0d want=%0d", i, d, a_rem[i], du % div_of(i));
                end
            end
            a_out_ready = 1'b1;
            tick();
            a_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b1;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b0;
        m_dividend  = 24'd0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_dividend  = 24'd0;

        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random_configs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
